// File: rtl/packet_rx_pkg.sv
// Shared frame constants and state encoding for the packet transmitter and receiver.
package packet_rx_pkg;
    localparam int         PKT_DATA_WIDTH = 54;
    localparam int         NBYTES         = 8;
    localparam int         DATA_BYTES     = NBYTES - 2;
    localparam logic       START_BIT      = 1'b1;
    localparam logic [7:0] STOP_BYTE      = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } rx_state_e;
endpackage

// File: rtl/packet_rx_parity.sv
// Even-parity generator shared with the transmitter: XOR of every payload bit.
module packet_rx_parity #(
    parameter int DATA_WIDTH = 54
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  parity
);
    assign parity = ^data;
endmodule

// File: rtl/packet_rx.sv
// Byte-serial 8-byte frame receiver: start/parity byte, six payload bytes, stop byte.
module packet_rx
    import packet_rx_pkg::*;
#(
    parameter int DATA_WIDTH = PKT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [7:0]            di,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  parity_err_o,
    output logic                  frame_err_o
);
    generate
        if (DATA_WIDTH != PKT_DATA_WIDTH) begin : g_width_chk
            $error("packet_rx: only DATA_WIDTH=54 is supported");
        end
    endgenerate

    rx_state_e             state, state_n;
    logic [2:0]            cnt, cnt_n;
    logic [DATA_WIDTH-1:0] payload, payload_n;
    logic                  par_bit, par_bit_n;
    logic                  par_calc;
    logic                  ok_n, perr_n, ferr_n;

    packet_rx_parity #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .data   (payload),
        .parity (par_calc)
    );

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        payload_n = payload;
        par_bit_n = par_bit;
        ok_n      = 1'b0;
        perr_n    = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && di[7] == START_BIT) begin
                    par_bit_n = di[6];
                    payload_n = {{(DATA_WIDTH-6){1'b0}}, di[5:0]};
                    cnt_n     = '0;
                    state_n   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (en) begin
                    payload_n = {payload[DATA_WIDTH-9:0], di};
                    cnt_n     = cnt + 3'd1;
                    if (cnt == 3'(DATA_BYTES - 1))
                        state_n = ST_STOP;
                end else begin
                    ferr_n    = 1'b1;
                    payload_n = '0;
                    state_n   = ST_IDLE;
                end
            end
            ST_STOP: begin
                if (!en) begin
                    ferr_n    = 1'b1;
                    payload_n = '0;
                    state_n   = ST_IDLE;
                end else if (di == STOP_BYTE) begin
                    // data_o is loaded from the current payload, so clearing the next one is safe
                    if (par_bit == par_calc) ok_n = 1'b1;
                    else                     perr_n = 1'b1;
                    payload_n = '0;
                    state_n   = ST_IDLE;
                end else begin
                    ferr_n = 1'b1;
                    if (di[7] == START_BIT) begin
                        par_bit_n = di[6];
                        payload_n = {{(DATA_WIDTH-6){1'b0}}, di[5:0]};
                        cnt_n     = '0;
                        state_n   = ST_DATA;
                    end else begin
                        payload_n = '0;
                        state_n   = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            payload      <= '0;
            par_bit      <= 1'b0;
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            payload      <= payload_n;
            par_bit      <= par_bit_n;
            valid_o      <= ok_n;
            parity_err_o <= perr_n;
            frame_err_o  <= ferr_n;
            if (ok_n) data_o <= payload;
        end
    end
endmodule

// File: tb/tb_packet_rx.sv
// Directed bench for packet_rx: good, parity-error, framing, abort, reset and back-to-back frames.
module tb_packet_rx;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  di;
    logic [53:0] data_o;
    logic        valid_o, parity_err_o, frame_err_o;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int vcnt   = 0;
    int vt_last = 0, vt_prev = 0;
    int excl_err = 0;

    localparam logic [53:0] ONES = 54'h3F_FFFF_FFFF_FFFF;

    packet_rx #(.DATA_WIDTH(54)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .di           (di),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid_o) begin
            vcnt++;
            vt_prev = vt_last;
            vt_last = cyc;
        end
        if (32'(valid_o) + 32'(parity_err_o) + 32'(frame_err_o) > 1) excl_err++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        en = 1'b1;
        di = b;
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0;
        di = 8'h00;
    endtask

    task automatic frame(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
        put(b0); put(b1); put(b2); put(b3);
        put(b4); put(b5); put(b6); put(b7);
    endtask

    task automatic pulses(input string tag, input logic v, input logic pe, input logic fe);
        check({tag, ".valid"}, 64'(valid_o), 64'(v));
        check({tag, ".perr"},  64'(parity_err_o), 64'(pe));
        check({tag, ".ferr"},  64'(frame_err_o), 64'(fe));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; di = 8'h00;
        repeat (3) @(negedge clk);
        pulses("reset", 1'b0, 1'b0, 1'b0);
        check("reset.data", 64'(data_o), 64'h0);
        rst = 1'b0;

        // good frame, payload 1
        frame(8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00);
        idle();
        pulses("good1", 1'b1, 1'b0, 1'b0);
        check("good1.data", 64'(data_o), 64'h1);
        idle();
        pulses("good1.next", 1'b0, 1'b0, 1'b0);

        // all-ones payload
        frame(8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00);
        idle();
        pulses("ones", 1'b1, 1'b0, 1'b0);
        check("ones.data", 64'(data_o), 64'(ONES));

        // parity error keeps previous data_o
        frame(8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00);
        idle();
        pulses("perr", 1'b0, 1'b1, 1'b0);
        check("perr.data", 64'(data_o), 64'(ONES));
        idle();
        pulses("perr.next", 1'b0, 1'b0, 1'b0);

        // bad stop byte that is itself a start byte
        frame(8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hC0);
        put(8'h00);
        pulses("badstop", 1'b0, 1'b0, 1'b1);
        put(8'h00); put(8'h00); put(8'h00); put(8'h00); put(8'h01); put(8'h00);
        idle();
        pulses("resync", 1'b1, 1'b0, 1'b0);
        check("resync.data", 64'(data_o), 64'h1);

        // abort after 3 bytes
        put(8'hC0); put(8'h00); put(8'h00);
        idle();
        idle();
        pulses("abort", 1'b0, 1'b0, 1'b1);
        frame(8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00);
        idle();
        pulses("after_abort", 1'b1, 1'b0, 1'b0);
        check("after_abort.data", 64'(data_o), 64'h3);

        // reset mid-frame
        put(8'hC0); put(8'h00); put(8'h00);
        @(negedge clk);
        en = 1'b0;
        rst = 1'b1;
        #1;
        pulses("midrst", 1'b0, 1'b0, 1'b0);
        check("midrst.data", 64'(data_o), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        pulses("rst_release", 1'b0, 1'b0, 1'b0);
        put(8'h05);
        frame(8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00);
        idle();
        pulses("after_rst", 1'b1, 1'b0, 1'b0);
        check("after_rst.data", 64'(data_o), 64'h1);

        // idle noise then back-to-back frames
        put(8'h00); put(8'h00); put(8'h7F);
        vcnt = 0;
        frame(8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00);
        put(8'hBF);
        pulses("b2b.first", 1'b1, 1'b0, 1'b0);
        check("b2b.first.data", 64'(data_o), 64'h1);
        put(8'hFF); put(8'hFF); put(8'hFF); put(8'hFF); put(8'hFF); put(8'hFF); put(8'h00);
        idle();
        pulses("b2b.second", 1'b1, 1'b0, 1'b0);
        check("b2b.second.data", 64'(data_o), 64'(ONES));
        idle();
        check("b2b.count", 64'(vcnt), 64'd2);
        check("b2b.spacing", 64'(vt_last - vt_prev), 64'd8);
        check("exclusive", 64'(excl_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/packet_rx.md
PACKET_RX -- requirements
Module: packet_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 54, payload width; only 54 is supported and any other value SHALL be rejected at elaboration.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port en  input  1  byte-valid strobe, di sampled only when high.
REQ-005 SHALL have port di  input  8  received packet byte.
REQ-006 SHALL have port data_o  output  54  last correctly received payload, big endian.
REQ-007 SHALL have port valid_o  output  1  one-cycle pulse, new good payload on data_o.
REQ-008 SHALL have port parity_err_o  output  1  one-cycle pulse, frame discarded on parity mismatch.
REQ-009 SHALL have port frame_err_o  output  1  one-cycle pulse, frame discarded on bad stop byte or abort.

Function
REQ-010 SHALL decode 8-byte frames: byte0 = {start bit 1, parity bit, payload[53:48]}; bytes1..6 = payload[47:0] MSB first; byte7 = 8'h00 stop byte.
REQ-011 SHALL compute expected parity as XOR of all 54 payload bits (even parity); frame is good when the received parity bit equals it.
REQ-012 SHALL use three states: IDLE, DATA, STOP; reset state IDLE.
REQ-013 IDLE: en=1 with di[7]=1 SHALL capture di[6] as parity and di[5:0] as payload[53:48], clear the byte counter, and go to DATA; en=1 with di[7]=0 SHALL be ignored; en=0 SHALL hold.
REQ-014 DATA: each en=1 byte SHALL shift into the payload register and increment the 3-bit byte counter; after the 6th data byte SHALL go to STOP.
REQ-015 STOP with en=1 and di=8'h00 and parity good: SHALL load data_o and pulse valid_o in the next cycle (latency 1 clk after stop byte sampled), then go to IDLE.
REQ-016 STOP with en=1 and di=8'h00 and parity bad: SHALL pulse parity_err_o next cycle, leave data_o and valid_o unchanged, then go to IDLE.
REQ-017 STOP with en=1 and di!=8'h00: SHALL pulse frame_err_o next cycle; if di[7]=1 SHALL treat di as a new start byte (REQ-013) and go to DATA, else go to IDLE.
REQ-018 en=0 in DATA or STOP SHALL abort the frame: pulse frame_err_o next cycle, go to IDLE, discard partial payload.
REQ-019 valid_o, parity_err_o, frame_err_o SHALL be registered, mutually exclusive, and high for exactly one cycle per event.
REQ-020 SHALL accept back-to-back frames: a start byte in the cycle after a stop byte SHALL be accepted with no gap.
REQ-021 data_o SHALL hold its value between good frames.

Reset
REQ-022 rst high SHALL immediately force state IDLE, byte counter 0, payload register 0, data_o 0, valid_o 0, parity_err_o 0, frame_err_o 0.
REQ-023 rst asserted mid-frame SHALL discard the frame with no error pulse; the first byte after release SHALL be evaluated in IDLE.

Structure
REQ-024 Frame constants (DATA_WIDTH 54, NBYTES 8, START_BIT 1'b1, STOP_BYTE 8'h00, state encoding) SHALL live in a shared package used by both packet and packet_rx.
REQ-025 Parity SHALL be computed by instantiating the existing parity sub-module with DATA_WIDTH 54 on the assembled payload.
REQ-026 Parity convention SHALL match the transmitter exactly; any change to it SHALL change both ends together.

Verification
REQ-027 Good frame: en=1, bytes C0 00 00 00 00 00 01 00 -> one cycle after last byte valid_o=1, data_o=54'h1, no error pulses.
REQ-028 All-ones: bytes BF FF FF FF FF FF FF 00 -> valid_o pulse, data_o=54'h3F_FFFF_FFFF_FFFF.
REQ-029 Parity error: bytes 80 00 00 00 00 00 01 00 -> parity_err_o pulse, valid_o=0, data_o unchanged.
REQ-030 Bad stop then resync: C0 00 00 00 00 00 01 C0, then 00 00 00 00 00 01 00 -> frame_err_o pulse after 8th byte, then valid_o pulse with data_o=54'h1.
REQ-031 Abort and reset: en dropped after 3 bytes -> frame_err_o pulse, state IDLE; rst pulsed mid-frame -> all outputs 0, no error pulse, next good frame decodes correctly.
REQ-032 Idle noise and back-to-back: 00 00 7F ignored, then two consecutive good frames with no gap -> two valid_o pulses exactly 8 cycles apart.
